// File: rtl/apb_rr_master_if.sv
// Bundles the requester-side and APB-side signals of apb_rr_master.
// master: the arbiter's view; slave: the environment (requesters plus APB fabric).
interface apb_rr_master_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic               pready;
  logic [DW-1:0]      prdata;
  logic               pslverr;

  modport master (
    input  req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
    output gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
    input  gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_rr_master_if.master      bus
);

  localparam int unsigned LW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [LW-1:0]   r_last;
  logic [NREQ-1:0] r_mask;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [DW-1:0]   r_rdata;
  logic            r_err;

  logic [NREQ-1:0] w_last_oh;
  logic [NREQ-1:0] w_elig;
  logic [LW-1:0]   w_win;
  logic [LW-1:0]   w_idx;
  logic            w_found;
  logic            w_timeout;
  logic            w_complete;
  logic            w_arb;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == StSetup) begin
      r_to_cnt <= '0;
    end else if (r_state == StAccess && !bus.pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Fires on the TO_CYCLES-th consecutive stalled ACCESS cycle.
  assign w_timeout = (r_state == StAccess) && !bus.pready &&
                     (r_to_cnt == CW'(TO_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_complete = (r_state == StAccess) && (bus.pready || w_timeout);

  always_comb begin
    w_last_oh         = '0;
    w_last_oh[r_last] = 1'b1;
  end

  // The finishing requester is masked in its own completion cycle, then via r_mask.
  always_comb begin
    w_elig  = bus.req & ~(w_complete ? w_last_oh : r_mask);
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = LW'((32'(r_last) + k) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_arb = w_found && ((r_state == StIdle) || w_complete);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   w_state_d = w_found ? StSetup : StIdle;
      StSetup:  w_state_d = StAccess;
      StAccess: begin
        if (w_complete) begin
          w_state_d = w_found ? StSetup : StIdle;
        end
      end
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= LW'(NREQ - 1);
      r_mask   <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= '0;
      r_mask <= '0;
      if (w_complete) begin
        r_done  <= w_last_oh;
        r_mask  <= w_last_oh;
        r_rdata <= (r_pwrite || w_timeout) ? '0 : bus.prdata;
        r_err   <= bus.pslverr || w_timeout;
      end
      if (w_arb) begin
        r_last   <= w_win;
        r_gnt    <= NREQ'(1) << w_win;
        r_pwrite <= bus.req_write[w_win];
        r_paddr  <= bus.req_addr[int'(w_win) * AW +: AW];
        r_pwdata <= bus.req_wdata[int'(w_win) * DW +: DW];
      end else if (w_complete) begin
        r_gnt <= '0;
      end
    end
  end

  always_comb begin
    bus.psel    = (r_state != StIdle);
    bus.penable = (r_state == StAccess);
    bus.pwrite  = r_pwrite;
    bus.paddr   = r_paddr;
    bus.pwdata  = r_pwdata;
    bus.gnt     = r_gnt;
    bus.done    = r_done;
    bus.rdata   = r_rdata;
    bus.err     = r_err;
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: vector table for single and back-to-back transfers,
// hand-written sequences for wait states, fairness, mid-transfer reset and timeout.
module tb_apb_rr_master;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  apb_rr_master_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_rr_master #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .TO_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        e_psel;
    logic        e_pen;
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [7:0]  e_paddr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.req    = '0;
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] w, logic rdy,
                              logic [31:0] prd, logic slv, logic ps, logic pe,
                              logic [3:0] g, logic [3:0] d, logic [31:0] rd,
                              logic e, logic [7:0] pa);
    vec_t v;
    v.rst = r; v.req = rq; v.wr = w; v.pready = rdy; v.prdata = prd; v.pslverr = slv;
    v.e_psel = ps; v.e_pen = pe; v.e_gnt = g; v.e_done = d; v.e_rdata = rd;
    v.e_err = e; v.e_paddr = pa;
    return v;
  endfunction

  initial begin
    logic [3:0] g[4];
    logic [3:0] g_exp[4];
    int         ng;
    int         k_done;
    logic       seen_done;
    logic [31:0] rd_at;
    logic        err_at;
    logic        psel_after;

    bus.req       = '0;
    bus.req_write = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*8 +: 8]   = 8'h10 + 8'(i * 16);
      bus.req_wdata[i*32 +: 32] = 32'hA0A0_0000 + 32'(i);
    end

    // Single read, then reset, then four back-to-back writes.
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'hDEADBEEF, 0, 1, 0, 4'b0001, 4'b0000, 32'h0, 0, 8'h10));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'hDEADBEEF, 0, 1, 1, 4'b0001, 4'b0000, 32'h0, 0, 8'h10));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 4'b0001, 32'hDEADBEEF, 0, 8'h10));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 4'b0000, 32'hDEADBEEF, 0, 8'h10));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 0, 4'b0001, 4'b0000, 32'h0, 0, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 1, 4'b0001, 4'b0000, 32'h0, 0, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 0, 4'b0010, 4'b0001, 32'h0, 0, 8'h20));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 1, 4'b0010, 4'b0000, 32'h0, 0, 8'h20));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 1, 32'hDEADBEEF, 1, 1, 0, 4'b0100, 4'b0010, 32'h0, 1, 8'h30));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 1, 4'b0100, 4'b0000, 32'h0, 1, 8'h30));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 0, 4'b1000, 4'b0100, 32'h0, 0, 8'h40));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 1, 32'hDEADBEEF, 0, 1, 1, 4'b1000, 4'b0000, 32'h0, 0, 8'h40));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 4'b1000, 32'h0, 0, 8'h40));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 0, 8'h40));

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst.psel", 32'(bus.psel), 0);
    chk("rst.penable", 32'(bus.penable), 0);
    chk("rst.pwrite", 32'(bus.pwrite), 0);
    chk("rst.paddr", 32'(bus.paddr), 0);
    chk("rst.pwdata", bus.pwdata, 0);
    chk("rst.gnt", 32'(bus.gnt), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.rdata", bus.rdata, 0);
    chk("rst.err", 32'(bus.err), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      bus.req       = tbl[i].req;
      bus.req_write = tbl[i].wr;
      bus.pready    = tbl[i].pready;
      bus.prdata    = tbl[i].prdata;
      bus.pslverr   = tbl[i].pslverr;
      tick();
      chk($sformatf("v%0d.psel", i), 32'(bus.psel), 32'(tbl[i].e_psel));
      chk($sformatf("v%0d.penable", i), 32'(bus.penable), 32'(tbl[i].e_pen));
      chk($sformatf("v%0d.gnt", i), 32'(bus.gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d.done", i), 32'(bus.done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d.rdata", i), bus.rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d.err", i), 32'(bus.err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d.paddr", i), 32'(bus.paddr), 32'(tbl[i].e_paddr));
    end

    // Wait states: five stalled ACCESS cycles, completion with slave error.
    do_reset();
    bus.req       = 4'b0010;
    bus.req_write = 4'b0000;
    bus.prdata    = 32'h1234_5678;
    tick();
    chk("ws.setup_psel", 32'(bus.psel), 1);
    chk("ws.setup_pen", 32'(bus.penable), 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ws%0d.psel", i), 32'(bus.psel), 1);
      chk($sformatf("ws%0d.penable", i), 32'(bus.penable), 1);
      chk($sformatf("ws%0d.paddr", i), 32'(bus.paddr), 32'h20);
      chk($sformatf("ws%0d.pwdata", i), bus.pwdata, 32'hA0A0_0001);
      chk($sformatf("ws%0d.done", i), 32'(bus.done), 0);
      if (i == 5) begin
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
      end
      tick();
    end
    chk("ws.done", 32'(bus.done), 32'b0010);
    chk("ws.err", 32'(bus.err), 1);
    chk("ws.rdata", bus.rdata, 32'h1234_5678);
    bus.req     = '0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    tick();
    chk("ws.done_once", 32'(bus.done), 0);
    chk("ws.err_hold", 32'(bus.err), 1);
    chk("ws.rdata_hold", bus.rdata, 32'h1234_5678);
    chk("ws.idle", 32'(bus.psel), 0);

    // Fairness: requester 1 continuous, requester 2 drops on its done and re-requests.
    do_reset();
    bus.req    = 4'b0110;
    bus.pready = 1'b1;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      tick();
      if (bus.psel && !bus.penable) begin
        g[ng] = bus.gnt;
        ng++;
      end
      bus.req[2] = ~bus.done[2];
    end
    chk("fair.count", 32'(ng), 4);
    g_exp[0] = 4'b0010; g_exp[1] = 4'b0100; g_exp[2] = 4'b0010; g_exp[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk($sformatf("fair.gnt%0d", i), 32'(g[i]), 32'(g_exp[i]));
    end

    // Lone requester 3 holding req: one IDLE arbitration cycle after its done.
    do_reset();
    bus.req    = 4'b1000;
    bus.pready = 1'b1;
    tick();
    chk("lone.gnt", 32'(bus.gnt), 32'b1000);
    tick();
    tick();
    chk("lone.done", 32'(bus.done), 32'b1000);
    chk("lone.done_psel", 32'(bus.psel), 0);
    tick();
    chk("lone.idle_psel", 32'(bus.psel), 0);
    tick();
    chk("lone.regrant_psel", 32'(bus.psel), 1);
    chk("lone.regrant_gnt", 32'(bus.gnt), 32'b1000);

    // Reset in mid-ACCESS.
    do_reset();
    bus.req    = 4'b0100;
    bus.pready = 1'b0;
    tick();
    tick();
    chk("mrst.in_access", 32'(bus.penable), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.psel", 32'(bus.psel), 0);
    chk("mrst.penable", 32'(bus.penable), 0);
    chk("mrst.gnt", 32'(bus.gnt), 0);
    bus.pready = 1'b1;
    tick();
    chk("mrst.no_done", 32'(bus.done), 0);
    rst     = 1'b0;
    bus.req = 4'b0101;
    tick();
    chk("mrst.first_gnt", 32'(bus.gnt), 32'b0001);
    chk("mrst.no_done2", 32'(bus.done), 0);

    // pready stuck low.
    do_reset();
    bus.req       = 4'b0001;
    bus.req_write = 4'b0000;
    bus.prdata    = 32'hFFFF_FFFF;
    bus.pslverr   = 1'b0;
    bus.pready    = 1'b0;
    tick();
    tick();
    k_done     = 0;
    seen_done  = 1'b0;
    rd_at      = '1;
    err_at     = 1'b0;
    psel_after = 1'b1;
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      tick();
      if (bus.done != 0) begin
        seen_done  = 1'b1;
        k_done     = k;
        rd_at      = bus.rdata;
        err_at     = bus.err;
        psel_after = bus.psel;
        bus.req    = '0;
      end
    end
`ifdef APB_TIMEOUT_EN
    chk("to.seen", 32'(seen_done), 1);
    chk("to.cycles", 32'(k_done), 16);
    chk("to.err", 32'(err_at), 1);
    chk("to.rdata", rd_at, 0);
    chk("to.idle", 32'(psel_after), 0);
`else
    chk("to.no_done", 32'(seen_done), 0);
    chk("to.psel_held", 32'(bus.psel), 1);
    chk("to.pen_held", 32'(bus.penable), 1);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
